bp_update_sched: RTL and testbench

Update scheduler for the branch predictor's 2-bit counter table. Sits between the MEM stage, which resolves branches, and the predictor's update port. Resolved outcomes are buffered in a small FIFO and retired into the table one per cycle. An update is deferred while fetch is reading the same table entry, with a starvation guard that forces it through after a bounded wait. The block also keeps a saturating misprediction count for performance monitoring.

---
 rtl/bp_pkg.sv | 9 +
 rtl/bp_fifo.sv | 42 ++++
 rtl/bp_update_sched.sv | 68 ++++++
 tb/tb_bp_update_sched.sv | 123 ++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch predictor update scheduler.
package bp_pkg;
  localparam int IDXW_DEF = 2;
  typedef enum logic [1:0] {EMPTY, READY, DEFER} bpupd_state_t;
  typedef struct packed {
    logic [IDXW_DEF-1:0] index;
    logic                taken;
  } bp_entry_t;
endpackage

// File: rtl/bp_fifo.sv
// bp_fifo: synchronous FIFO with a separate occupancy counter for full/empty.
module bp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 3,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_din;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: buffers resolved branches and retires them into the 2-bit counter table,
// deferring one cycle on a fetch read of the same entry, and counts mispredictions.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IDXW  = IDXW_DEF,
  parameter  int CNTW  = 16,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            res_valid,
  input  logic [IDXW-1:0] res_index,
  input  logic            res_taken,
  input  logic            res_mispred,
  output logic            res_ready,
  input  logic            if_rd_valid,
  input  logic [IDXW-1:0] if_rd_index,
  output logic            upd_en,
  output logic [IDXW-1:0] upd_index,
  output logic            upd_taken,
  output logic [CW-1:0]   pending,
  input  logic            clr_stats,
  output logic [CNTW-1:0] miss_count
);
  typedef struct packed {
    logic [IDXW-1:0] index;
    logic            taken;
  } entry_t;
  entry_t       w_head;
  logic         w_full, w_empty, w_push, w_conflict;
  logic [CW-1:0] w_cnt_next;
  bpupd_state_t r_state, w_next;
  logic [CNTW-1:0] r_miss;
  bp_fifo #(.DEPTH(DEPTH), .W(IDXW+1)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_pop   (upd_en),
    .i_din   ({res_index, res_taken}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );
  assign res_ready  = ~w_full;
  assign w_push     = res_valid & ~w_full;
  assign w_conflict = if_rd_valid & (if_rd_index == w_head.index);
  assign upd_en     = (r_state == READY & ~w_conflict) | (r_state == DEFER);
  assign upd_index  = r_state == EMPTY ? '0 : w_head.index;
  assign upd_taken  = r_state == EMPTY ? 1'b0 : w_head.taken;
  assign miss_count = r_miss;
  assign w_cnt_next = pending + CW'(w_push) - CW'(upd_en);
  // A freshly pushed entry only becomes issuable via the registered state, so there is no bypass.
  always_comb
    w_next = (!upd_en && r_state == READY) ? DEFER : (w_cnt_next == '0 ? EMPTY : READY);
  always_ff @(posedge CLK) begin
    if (RST) r_state <= EMPTY;
    else r_state <= w_next;
  end
  always_ff @(posedge CLK) begin
    if (RST || clr_stats) r_miss <= '0;
    else if (w_push && res_mispred && !(&r_miss)) r_miss <= r_miss + CNTW'(1);
  end
  logic w_unused;
  assign w_unused = w_empty;
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed and random stimulus against a queue-based reference model.
module tb_bp_update_sched;
  logic       CLK = 0, RST = 1, rv = 0, rt = 0, rm = 0, fv = 0, clr = 0;
  logic [1:0] ri = 0, fi = 0;
  logic       ready, en, tk, ready4, en4, tk4;
  logic [1:0] idx, idx4;
  logic [2:0] pend, pend4;
  logic [15:0] miss;
  logic [3:0]  miss4;
  int total = 0, bad = 0;
  bit [2:0] q[$];
  bit m_def = 0;
  int m_miss = 0, m_miss4 = 0;

  always #5 CLK = ~CLK;

  bp_update_sched dut (
    .CLK(CLK), .RST(RST), .res_valid(rv), .res_index(ri), .res_taken(rt), .res_mispred(rm),
    .res_ready(ready), .if_rd_valid(fv), .if_rd_index(fi), .upd_en(en), .upd_index(idx),
    .upd_taken(tk), .pending(pend), .clr_stats(clr), .miss_count(miss)
  );
  bp_update_sched #(.CNTW(4)) dut4 (
    .CLK(CLK), .RST(RST), .res_valid(rv), .res_index(ri), .res_taken(rt), .res_mispred(rm),
    .res_ready(ready4), .if_rd_valid(fv), .if_rd_index(fi), .upd_en(en4), .upd_index(idx4),
    .upd_taken(tk4), .pending(pend4), .clr_stats(clr), .miss_count(miss4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit [1:0] i, input bit t, input bit mp,
                     input bit f, input bit [1:0] fidx, input bit c);
    int  n;
    bit  e_en, e_tk, push_ok;
    bit [1:0] e_idx;
    RST = r; rv = v; ri = i; rt = t; rm = mp; fv = f; fi = fidx; clr = c;
    @(negedge CLK);
    n = q.size();
    e_en = 0; e_idx = 0; e_tk = 0;
    if (n > 0) begin
      e_idx = q[0][2:1];
      e_tk  = q[0][0];
      e_en  = m_def || !(f && fidx == e_idx);
    end
    check("ready", int'(ready), int'(n < 4));
    check("pending", int'(pend), n);
    check("upd_en", int'(en), int'(e_en));
    check("upd_index", int'(idx), int'(e_idx));
    check("upd_taken", int'(tk), int'(e_tk));
    check("miss", int'(miss), m_miss);
    check("miss4", int'(miss4), m_miss4);
    check("ready4", int'(ready4), int'(n < 4));
    check("pend4", int'(pend4), n);
    check("en4", int'(en4), int'(e_en));
    check("idx4", int'(idx4), int'(e_idx));
    check("tk4", int'(tk4), int'(e_tk));
    if (r) begin
      q.delete();
      m_def = 0; m_miss = 0; m_miss4 = 0;
    end else begin
      push_ok = v && n < 4;
      if (e_en) begin
        void'(q.pop_front());
        m_def = 0;
      end else if (n > 0) m_def = 1;
      if (push_ok) q.push_back({i, t});
      if (c) begin
        m_miss = 0; m_miss4 = 0;
      end else if (push_ok && mp) begin
        if (m_miss < 65535) m_miss++;
        if (m_miss4 < 15) m_miss4++;
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    @(posedge CLK); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // queue entries with fetch blocking, then reset over them
    for (int k = 0; k < 3; k++) cyc(0, 1, 2'd1, 1, 1, 1, 2'd1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // single push
    cyc(0, 1, 2'd2, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // conflict on head index 1
    cyc(0, 1, 2'd1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1, 2'd1, 0);
    // fill under conflict, then wrap over 10 pushes
    for (int k = 0; k < 5; k++) cyc(0, 1, 2'd3, k[0], 0, 1, 2'd3, 0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 2'(k), k[1], 0, 1, 2'(k), 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous push/pop at pending 2
    cyc(0, 1, 2'd0, 1, 0, 1, 2'd0, 0);
    cyc(0, 1, 2'd1, 0, 0, 1, 2'd0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'(k), k[0], 0, 1, 2'd3, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // miss counting and saturation
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 2'(k), 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 17; k++) cyc(0, 1, 2'(k), 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd2, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 2) != 0, 2'($urandom), $urandom_range(0, 99) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
